// File: rtl/tex_spi_rom_responder_pkg.sv
// tex_spi_pkg
//   Shared constants for the texture SPI ROM responder: supported opcodes,
//   address/dummy phase lengths and the responder state encoding.
//   The dual-output read opcode is only honoured when TEX_SPI_ROM_DUAL_EN
//   is defined at build time.

package tex_spi_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_DUAL_READ = 8'h3B;
    localparam int         ADDR_BITS     = 24;
    localparam int         DUMMY_CLKS    = 8;

    // Responder states, kept as plain constants so older tools can consume them.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DUMMY  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

endpackage

// File: rtl/tex_spi_rom_responder_sync.sv
// spi_pin_sync
//   Brings the asynchronous SPI pins into the system clock domain through
//   SYNC_STAGES flops and derives single-cycle sclk edge strobes.
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   spi_csb       chip select pin (active low)
//   spi_sclk      SPI clock pin
//   spi_io_in     io pins [2:0]
//   sclk_rise     one-cycle strobe for a synchronised rising sclk edge
//   sclk_fall     one-cycle strobe for a synchronised falling sclk edge
//   cs_active     synchronised chip select, 1 = selected
//   io_s          synchronised io pins, aligned with the edge strobes

module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_csb,
    input  logic       spi_sclk,
    input  logic [2:0] spi_io_in,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       cs_active,
    output logic [2:0] io_s
);

    logic [SYNC_STAGES-1:0]      csbSync_q;
    logic [SYNC_STAGES-1:0]      sclkSync_q;
    logic [SYNC_STAGES-1:0][2:0] ioSync_q;
    logic                        sclkPrev_q;

    // csb resets to the deselected level so reset never looks like a select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csbSync_q  <= '1;
            sclkSync_q <= '0;
            ioSync_q   <= '0;
            sclkPrev_q <= 1'b0;
        end else begin
            csbSync_q  <= {csbSync_q[SYNC_STAGES-2:0], spi_csb};
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi_sclk};
            ioSync_q   <= {ioSync_q[SYNC_STAGES-2:0], spi_io_in};
            sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclkSync_q[SYNC_STAGES-1] & ~sclkPrev_q;
    assign sclk_fall = ~sclkSync_q[SYNC_STAGES-1] & sclkPrev_q;
    assign cs_active = ~csbSync_q[SYNC_STAGES-1];
    assign io_s      = ioSync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tex_spi_rom_responder.sv
// tex_spi_rom_responder
//   SPI flash responder (mode 0) that streams texture bytes out of a
//   synchronous ROM. Decodes opcode, 24-bit address and optional dummy
//   phase, then shifts ROM bytes out with address auto-increment (wrapping
//   modulo 2^MEM_AW) until chip select rises.
//   Build option: TEX_SPI_ROM_DUAL_EN enables the 0x3B dual-output read;
//   without it 0x3B is ignored and io[0] is never driven.
// Ports
//   clk, rst_n    system clock (>= 8x sclk), asynchronous active-low reset
//   spi_csb       chip select, active low
//   spi_sclk      SPI clock (sample rising, drive falling)
//   spi_io_in     io[0] = MOSI, io[1]/io[2] unused as inputs
//   spi_io_out    driven data, io[2] always 0
//   spi_io_oe     per-pin output enable, 1 = drive
//   mem_re        ROM read strobe, one clk per byte
//   mem_addr      ROM byte address, valid with mem_re
//   mem_rdata     ROM data, valid one clk after mem_re
//   busy          high while a transaction is being handled

module tex_spi_rom_responder
    import tex_spi_pkg::*;
#(
    parameter int MEM_AW      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_csb,
    input  logic              spi_sclk,
    input  logic [2:0]        spi_io_in,
    output logic [2:0]        spi_io_out,
    output logic [2:0]        spi_io_oe,
    output logic              mem_re,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    logic       sclkRise;
    logic       sclkFall;
    logic       csActive;
    logic [2:0] ioS;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_csb   (spi_csb),
        .spi_sclk  (spi_sclk),
        .spi_io_in (spi_io_in),
        .sclk_rise (sclkRise),
        .sclk_fall (sclkFall),
        .cs_active (csActive),
        .io_s      (ioS)
    );

    logic [2:0]        state_q,  state_d;
    logic [4:0]        bitCnt_q, bitCnt_d;
    logic [7:0]        cmd_q,    cmd_d;
    logic [MEM_AW-1:0] addr_q,   addr_d;
    logic [7:0]        shift_q,  shift_d;
    logic              memRe_q,  memRe_d;
    logic              load_q,   load_d;
    logic              d1_q,     d1_d;
    logic              oe1_q,    oe1_d;
    logic [4:0]        lastDataBit;
    logic [7:0]        cmdNext;
`ifdef TEX_SPI_ROM_DUAL_EN
    logic              dual_q,   dual_d;
    logic              d0_q,     d0_d;
    logic              oe0_q,    oe0_d;

    assign lastDataBit = dual_q ? 5'd3 : 5'd7;
`else
    assign lastDataBit = 5'd7;
`endif

    assign cmdNext = {cmd_q[6:0], ioS[0]};

    // Next-state logic. Deselect has priority over any coincident sclk edge.
    // A ROM fetch (memRe_q) is followed one clk later by load_q, which captures
    // mem_rdata and pre-increments the address for the next fetch; a deselect
    // in between drops the load so the fetched byte is discarded.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        memRe_d  = 1'b0;
        load_d   = 1'b0;
        d1_d     = d1_q;
        oe1_d    = oe1_q;
`ifdef TEX_SPI_ROM_DUAL_EN
        dual_d   = dual_q;
        d0_d     = d0_q;
        oe0_d    = oe0_q;
`endif
        if (!csActive) begin
            state_d  = S_IDLE;
            bitCnt_d = '0;
            d1_d     = 1'b0;
            oe1_d    = 1'b0;
`ifdef TEX_SPI_ROM_DUAL_EN
            dual_d   = 1'b0;
            d0_d     = 1'b0;
            oe0_d    = 1'b0;
`endif
        end else begin
            load_d = memRe_q;
            if (load_q) begin
                shift_d = mem_rdata;
                addr_d  = addr_q + MEM_AW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    state_d  = S_CMD;
                    bitCnt_d = '0;
                end
                S_CMD: begin
                    if (sclkRise) begin
                        cmd_d = cmdNext;
                        if (bitCnt_q == 5'd7) begin
                            bitCnt_d = '0;
                            if (cmdNext == CMD_READ) begin
                                state_d = S_ADDR;
`ifdef TEX_SPI_ROM_DUAL_EN
                                dual_d  = 1'b0;
                            end else if (cmdNext == CMD_DUAL_READ) begin
                                state_d = S_ADDR;
                                dual_d  = 1'b1;
`endif
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            bitCnt_d = bitCnt_q + 5'd1;
                        end
                    end
                end
                S_ADDR: begin
                    // Only the low MEM_AW address bits survive; upper bits alias.
                    if (sclkRise) begin
                        addr_d = {addr_q[MEM_AW-2:0], ioS[0]};
                        if (bitCnt_q == 5'(ADDR_BITS - 1)) begin
                            bitCnt_d = '0;
                            memRe_d  = 1'b1;
`ifdef TEX_SPI_ROM_DUAL_EN
                            state_d  = dual_q ? S_DUMMY : S_DATA;
`else
                            state_d  = S_DATA;
`endif
                        end else begin
                            bitCnt_d = bitCnt_q + 5'd1;
                        end
                    end
                end
                S_DUMMY: begin
                    if (sclkRise) begin
                        if (bitCnt_q == 5'(DUMMY_CLKS - 1)) begin
                            bitCnt_d = '0;
                            state_d  = S_DATA;
                        end else begin
                            bitCnt_d = bitCnt_q + 5'd1;
                        end
                    end
                end
                S_DATA: begin
                    // Drive on falling edges; the rising edge that samples the
                    // last bit of a byte fetches the next one, which is loaded
                    // well before the following falling edge.
                    if (sclkFall) begin
`ifdef TEX_SPI_ROM_DUAL_EN
                        if (dual_q) begin
                            d1_d    = shift_q[7];
                            d0_d    = shift_q[6];
                            oe1_d   = 1'b1;
                            oe0_d   = 1'b1;
                            shift_d = {shift_q[5:0], 2'b00};
                        end else begin
                            d1_d    = shift_q[7];
                            oe1_d   = 1'b1;
                            shift_d = {shift_q[6:0], 1'b0};
                        end
`else
                        d1_d    = shift_q[7];
                        oe1_d   = 1'b1;
                        shift_d = {shift_q[6:0], 1'b0};
`endif
                    end
                    if (sclkRise) begin
                        if (bitCnt_q == lastDataBit) begin
                            bitCnt_d = '0;
                            memRe_d  = 1'b1;
                        end else begin
                            bitCnt_d = bitCnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IGNORE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bitCnt_q <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            shift_q  <= '0;
            memRe_q  <= 1'b0;
            load_q   <= 1'b0;
            d1_q     <= 1'b0;
            oe1_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            memRe_q  <= memRe_d;
            load_q   <= load_d;
            d1_q     <= d1_d;
            oe1_q    <= oe1_d;
        end
    end

`ifdef TEX_SPI_ROM_DUAL_EN
    // Dual-read mode flag and io[0] output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dual_q <= 1'b0;
            d0_q   <= 1'b0;
            oe0_q  <= 1'b0;
        end else begin
            dual_q <= dual_d;
            d0_q   <= d0_d;
            oe0_q  <= oe0_d;
        end
    end

    assign spi_io_out = {1'b0, d1_q, d0_q};
    assign spi_io_oe  = {1'b0, oe1_q, oe0_q};
`else
    assign spi_io_out = {1'b0, d1_q, 1'b0};
    assign spi_io_oe  = {1'b0, oe1_q, 1'b0};
`endif

    assign mem_re   = memRe_q;
    assign mem_addr = addr_q;
    assign busy     = (state_q != S_IDLE);

    // Byte fetches are at least one sclk apart, so never on adjacent clocks.
    assert property (@(posedge clk) disable iff (!rst_n) mem_re |=> !mem_re);

endmodule
